// File: rtl/keyboard_pkg.sv
// Shared scan-code constants and FSM state types for the PS/2 keyboard front end.
package keyboard_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam logic [7:0] SC_EMPTY   = 8'h00;
  localparam logic [7:0] SC_ERROR   = 8'hFF;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
  typedef enum logic {MAKE, BREAK_SEEN} code_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, kb_clk glitch filter, falling-edge detect,
// 11-bit frame FSM and inter-edge timeout. Reports one byte or one error per frame.
module ps2_frame_rx
  import keyboard_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kb_clk,
  input  logic       kb_data,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       rx_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_meta, clk_sync, data_meta, data_sync;
  logic          clk_filt, clk_filt_d;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  frame_state_t  state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift_reg, shift_nxt;
  logic          par_bit, par_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic          done_nxt, err_nxt;

  // The filtered level only follows the synced pin after FILTER_LEN differing samples in a row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta   <= 1'b1;
      clk_sync   <= 1'b1;
      data_meta  <= 1'b1;
      data_sync  <= 1'b1;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_meta   <= kb_clk;
      clk_sync   <= clk_meta;
      data_meta  <= kb_data;
      data_sync  <= data_meta;
      clk_filt_d <= clk_filt;
      if (clk_sync == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      tmo_cnt   <= '0;
      rx_byte   <= '0;
      rx_done   <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
      par_bit   <= par_nxt;
      tmo_cnt   <= tmo_nxt;
      rx_done   <= done_nxt;
      rx_err    <= err_nxt;
      if (done_nxt) rx_byte <= shift_reg;
    end
  end

  // Timeout counter is pinned at zero in IDLE, so it can never wrap between frames
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    par_nxt     = par_bit;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    tmo_nxt     = (state == IDLE || fall) ? '0 : tmo_cnt + TW'(1);
    if (fall) begin
      case (state)
        IDLE: begin
          if (!data_sync) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end
        end
        DATA: begin
          shift_nxt   = {data_sync, shift_reg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_nxt   = data_sync;
          state_nxt = STOP;
        end
        default: begin
          state_nxt = IDLE;
          if (data_sync && (^{shift_reg, par_bit})) done_nxt = 1'b1;
          else                                      err_nxt  = 1'b1;
        end
      endcase
    end else if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_nxt = IDLE;
      tmo_nxt   = '0;
      err_nxt   = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// Keyboard front end: strips E0/F0 prefixes from received frames and emits one
// registered scan code per key release, or 8'hFF on a bad frame.
module ps2_scan_decoder
  import keyboard_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kb_clk,
  input  logic       kb_data,
  output logic [7:0] scan_code_out,
  output logic       code_valid,
  output logic       frame_err
);

  logic [7:0]  rx_byte;
  logic        rx_done, rx_err;
  code_state_t code_state, code_nxt;
  logic [7:0]  scan_nxt;
  logic        valid_nxt, ferr_nxt;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk    (clk),
    .rst_n  (rst_n),
    .kb_clk (kb_clk),
    .kb_data(kb_data),
    .rx_byte(rx_byte),
    .rx_done(rx_done),
    .rx_err (rx_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_state    <= MAKE;
      scan_code_out <= SC_EMPTY;
      code_valid    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      code_state    <= code_nxt;
      scan_code_out <= scan_nxt;
      code_valid    <= valid_nxt;
      frame_err     <= ferr_nxt;
    end
  end

  // Only the code following a break prefix is reported; make codes and repeats are dropped
  always_comb begin
    code_nxt  = code_state;
    scan_nxt  = scan_code_out;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    if (rx_err) begin
      scan_nxt  = SC_ERROR;
      valid_nxt = 1'b1;
      ferr_nxt  = 1'b1;
      code_nxt  = MAKE;
    end else if (rx_done && rx_byte != EXT_CODE) begin
      if (rx_byte == BREAK_CODE) begin
        code_nxt = BREAK_SEEN;
      end else if (code_state == BREAK_SEEN) begin
        scan_nxt  = rx_byte;
        valid_nxt = 1'b1;
        code_nxt  = MAKE;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder; PS/2 bit period and timeout are scaled down
// (80 clk per bit, 2000-cycle timeout) so the whole sequence stays short.
module tb_ps2_scan_decoder;

  localparam int FILTER_LEN = 8;
  localparam int TMO        = 2000;
  localparam int HALF       = 40;
  localparam int LATENCY    = FILTER_LEN + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kb_clk = 1'b1;
  logic       kb_data = 1'b1;
  logic [7:0] scan_code_out;
  logic       code_valid, frame_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int valid_cnt = 0, err_cnt = 0, both_cnt = 0;
  int last_valid_cyc = 0, stop_cyc = 0;
  int v0, e0, b0;

  ps2_scan_decoder #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .kb_clk       (kb_clk),
    .kb_data      (kb_data),
    .scan_code_out(scan_code_out),
    .code_valid   (code_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse counters sampled half a cycle after each active edge
  always @(negedge clk) begin
    if (code_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (frame_err) err_cnt++;
    if (code_valid && frame_err) both_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Sends the first nbits bits of an 11-bit frame; data changes mid-low-phase
  task automatic applyStimulus(input logic [7:0] code, input bit bad_par, input int nbits, input bit glitch);
    logic [10:0] bits;
    bits = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    @(negedge clk);
    kb_data = bits[0];
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      kb_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (HALF / 2) @(negedge clk);
      kb_data = (i < 10) ? bits[i+1] : 1'b1;
      repeat (HALF / 2) @(negedge clk);
      kb_clk = 1'b1;
      if (glitch) begin
        repeat (16) @(negedge clk);
        kb_clk = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk);
        kb_clk = 1'b1;
        repeat (HALF - 16 - (FILTER_LEN - 1)) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    kb_data = 1'b1;
  endtask

  task automatic snap();
    v0 = valid_cnt;
    e0 = err_cnt;
    b0 = both_cnt;
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("reset_scan", 32'(scan_code_out), 32'h00);
    checkOutput("reset_valid", 32'(code_valid), 32'd0);
    checkOutput("reset_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;

    // Scenario 1: idle keyboard
    snap();
    repeat (10000) @(negedge clk);
    checkOutput("idle_scan", 32'(scan_code_out), 32'h00);
    checkOutput("idle_pulses", 32'(valid_cnt - v0), 32'd0);

    // Scenario 2: key "1" press and release
    snap();
    applyStimulus(8'h16, 1'b0, 11, 1'b0);
    checkOutput("make_only_pulses", 32'(valid_cnt - v0), 32'd0);
    applyStimulus(8'hF0, 1'b0, 11, 1'b0);
    applyStimulus(8'h16, 1'b0, 11, 1'b0);
    checkOutput("s2_pulses", 32'(valid_cnt - v0), 32'd1);
    checkOutput("s2_scan", 32'(scan_code_out), 32'h16);
    checkOutput("s2_latency", 32'(last_valid_cyc - stop_cyc), 32'(LATENCY));
    checkOutput("s2_err", 32'(err_cnt - e0), 32'd0);

    // Scenario 3: extended break, then typematic repeats
    snap();
    applyStimulus(8'hE0, 1'b0, 11, 1'b0);
    applyStimulus(8'hF0, 1'b0, 11, 1'b0);
    applyStimulus(8'h45, 1'b0, 11, 1'b0);
    checkOutput("s3a_pulses", 32'(valid_cnt - v0), 32'd1);
    checkOutput("s3a_scan", 32'(scan_code_out), 32'h45);
    snap();
    repeat (3) applyStimulus(8'h1E, 1'b0, 11, 1'b0);
    checkOutput("s3_repeat_hold", 32'(scan_code_out), 32'h45);
    applyStimulus(8'hF0, 1'b0, 11, 1'b0);
    applyStimulus(8'h1E, 1'b0, 11, 1'b0);
    checkOutput("s3b_pulses", 32'(valid_cnt - v0), 32'd1);
    checkOutput("s3b_scan", 32'(scan_code_out), 32'h1E);

    // Scenario 4: parity error, then recovery
    snap();
    applyStimulus(8'h26, 1'b1, 11, 1'b0);
    checkOutput("par_scan", 32'(scan_code_out), 32'hFF);
    checkOutput("par_both", 32'(both_cnt - b0), 32'd1);
    checkOutput("par_err", 32'(err_cnt - e0), 32'd1);
    checkOutput("par_latency", 32'(last_valid_cyc - stop_cyc), 32'(LATENCY));
    snap();
    applyStimulus(8'hF0, 1'b0, 11, 1'b0);
    applyStimulus(8'h26, 1'b0, 11, 1'b0);
    checkOutput("s4_scan", 32'(scan_code_out), 32'h26);
    checkOutput("s4_err", 32'(err_cnt - e0), 32'd0);

    // Scenario 5: frame stalls after four data bits
    snap();
    applyStimulus(8'h5A, 1'b0, 5, 1'b0);
    repeat (TMO + 500) @(negedge clk);
    checkOutput("tmo_err", 32'(err_cnt - e0), 32'd1);
    checkOutput("tmo_valid", 32'(valid_cnt - v0), 32'd1);
    checkOutput("tmo_scan", 32'(scan_code_out), 32'hFF);
    snap();
    applyStimulus(8'hF0, 1'b0, 11, 1'b0);
    applyStimulus(8'h3D, 1'b0, 11, 1'b0);
    checkOutput("s5_scan", 32'(scan_code_out), 32'h3D);
    checkOutput("s5_err", 32'(err_cnt - e0), 32'd0);

    // Scenario 6: sub-filter glitches, then reset mid-frame
    snap();
    applyStimulus(8'hF0, 1'b0, 11, 1'b1);
    applyStimulus(8'h4D, 1'b0, 11, 1'b1);
    checkOutput("glitch_scan", 32'(scan_code_out), 32'h4D);
    checkOutput("glitch_pulses", 32'(valid_cnt - v0), 32'd1);
    checkOutput("glitch_err", 32'(err_cnt - e0), 32'd0);
    applyStimulus(8'hF0, 1'b0, 6, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_scan", 32'(scan_code_out), 32'h00);
    checkOutput("midrst_valid", 32'(code_valid), 32'd0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    snap();
    applyStimulus(8'hF0, 1'b0, 11, 1'b0);
    applyStimulus(8'h2E, 1'b0, 11, 1'b0);
    checkOutput("s6_scan", 32'(scan_code_out), 32'h2E);
    checkOutput("s6_pulses", 32'(valid_cnt - v0), 32'd1);
    checkOutput("s6_err", 32'(err_cnt - e0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
